// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, sitting beside `ram` on the data-memory port.
// Optional even-parity bit enabled by defining MMIO_UART_PARITY_EN.
module mmio_uart_tx #(
    parameter logic [29:0] BASE_WADDR  = 30'h0000_4000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] r_addr,
    output logic [31:0] r_val,
    input  logic        w_enable,
    input  logic [29:0] w_addr,
    input  logic [31:0] w_val,
    input  logic [3:0]  w_byte_en,
    output logic        txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic PARITY_FLAG = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    localparam logic PARITY_FLAG = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          txd_q, txd_d;
    logic          frame_done;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;

    logic [15:0]   div_q;
    logic [31:0]   txcnt_q;
    logic          ovf_q;
    logic [31:0]   r_val_q, r_val_d;

    logic          w_hit, r_hit;
    logic [1:0]    w_off;
    logic          push_req, push, pop, full, empty, busy;
    logic          ovf_clr, cnt_clr;
    logic [15:0]   eff_div;
    logic          bit_done;
    logic          unused_ok;

    assign w_hit    = w_enable && (w_addr[29:2] == BASE_WADDR[29:2]);
    assign r_hit    = (r_addr[29:2] == BASE_WADDR[29:2]);
    assign w_off    = w_addr[1:0];

    assign full     = (fifo_cnt_q == FULL_CNT);
    assign empty    = (fifo_cnt_q == '0);
    assign busy     = (state_q != IDLE);

    // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign push_req = w_hit && (w_off == 2'd0) && w_byte_en[0];
    assign push     = push_req && !full;
    assign pop      = (state_q == IDLE) && !empty;

    assign ovf_clr  = w_hit && (w_off == 2'd1) && w_byte_en[0] && w_val[3];
    assign cnt_clr  = w_hit && (w_off == 2'd3);

    assign eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_done = (baud_q == bit_div_q - 16'd1);

    assign unused_ok = ^{w_val[31:16], w_byte_en[3:2]};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= w_val[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DEFAULT_DIV;
        end else if (w_hit && (w_off == 2'd2)) begin
            if (w_byte_en[0]) begin
                div_q[7:0] <= w_val[7:0];
            end
            if (w_byte_en[1]) begin
                div_q[15:8] <= w_val[15:8];
            end
        end
    end

    // A clear landing on the same edge as a frame completion wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txcnt_q <= '0;
        end else if (cnt_clr) begin
            txcnt_q <= '0;
        end else if (frame_done) begin
            txcnt_q <= txcnt_q + 32'd1;
        end
    end

    always_comb begin
        r_val_d = 32'd0;
        if (r_hit) begin
            case (r_addr[1:0])
                2'd1:    r_val_d = {27'd0, PARITY_FLAG, ovf_q, full, empty, busy};
                2'd2:    r_val_d = {16'd0, div_q};
                2'd3:    r_val_d = txcnt_q;
                default: r_val_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val_q <= '0;
        end else begin
            r_val_q <= r_val_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_div_q <= 16'd1;
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_div_q <= bit_div_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
        end
    end

    // txd_d is the line level for the state being entered, so txd itself is a plain flop.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_div_d  = bit_div_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    data_d    = fifo_mem[rd_ptr_q];
                    bit_div_d = eff_div;
                    baud_d    = '0;
                    txd_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    txd_d     = data_q[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        txd_d   = ^data_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = data_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    baud_d     = '0;
                    txd_d      = 1'b1;
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign r_val = r_val_q;
    assign txd   = txd_q;

endmodule
